// File: rtl/audio_csr_bank.sv
// audio_csr_bank: APB register bank for an audio block. Holds the control,
// interrupt and volume-target registers and ramps each channel's volume
// toward its target on ramp_tick, raising an interrupt when a ramp finishes.
module audio_csr_bank #(
    parameter int          NUM_CH   = 4,
    parameter int          NUM_IRQ  = 8,
    parameter logic [15:0] STEP_RST = 16'h0010
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic [11:0]          paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    input  logic [31:0]          version,
    input  logic [NUM_IRQ-1:0]   irq_src,
    input  logic                 ramp_tick,
    output logic [7:0]           ctrl_enable,
    output logic [NUM_CH*16-1:0] vol_out,
    output logic [NUM_CH-1:0]    ramp_busy,
    output logic                 irq
);

    localparam int IW = NUM_IRQ + 1;

    // Bus handshake: a transfer is accepted in its first access cycle
    // (psel & penable & ~pready); address, direction, data and read data are
    // captured there, pready is high for exactly the following cycle, and a
    // write is committed on the clock edge that ends that pready cycle.
    logic access;
    assign access = psel & penable & ~pready;

    logic [7:0]        ctrl_en_q;
    logic              bypass_q;
    logic [IW-1:0]     int_en_q;
    logic [IW-1:0]     int_stat_q;
    logic [15:0]       ramp_step_q;
    logic [15:0]       vol_tgt [NUM_CH];
    logic [15:0]       vol_cur [NUM_CH];
    logic [NUM_IRQ-1:0] irq_hist_q;
    logic              edge_en_q;

    // Write strobes are high only during the pready cycle of a good write.
    logic              wr_ctrl, wr_int_en, wr_int_clr, wr_int_set, wr_step;
    logic [NUM_CH-1:0] wr_tgt;
    logic [31:0]       wr_data;

    logic [31:0]       rd_data;
    logic              acc_err;
    logic              hit_ctrl, hit_int_en, hit_int_stat, hit_int_set, hit_step;
    logic [NUM_CH-1:0] hit_tgt;
    logic              ch_hit;

    // Address decode, read mux and error detection for the current address.
    always_comb begin
        rd_data      = '0;
        acc_err      = 1'b0;
        hit_ctrl     = 1'b0;
        hit_int_en   = 1'b0;
        hit_int_stat = 1'b0;
        hit_int_set  = 1'b0;
        hit_step     = 1'b0;
        hit_tgt      = '0;
        ch_hit       = 1'b0;
        if (paddr[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end else begin
            case (paddr[11:2])
                10'h000: begin
                    hit_ctrl = 1'b1;
                    rd_data  = {bypass_q, 23'b0, ctrl_en_q};
                end
                10'h001: begin
                    rd_data = version;
                    acc_err = pwrite;
                end
                10'h002: begin
                    hit_int_en = 1'b1;
                    rd_data    = 32'(int_en_q);
                end
                10'h003: begin
                    hit_int_stat = 1'b1;
                    rd_data      = 32'(int_stat_q);
                end
                10'h004: hit_int_set = 1'b1;
                10'h005: begin
                    hit_step = 1'b1;
                    rd_data  = {16'b0, ramp_step_q};
                end
                default: begin
                    if (paddr[11:8] == 4'h1) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                            if (paddr[6:2] == 5'(n)) begin
                                ch_hit = 1'b1;
                                if (!paddr[7]) begin
                                    hit_tgt[n] = 1'b1;
                                    rd_data    = {16'b0, vol_tgt[n]};
                                end else begin
                                    rd_data = {16'b0, vol_cur[n]};
                                end
                            end
                        end
                        acc_err = ~ch_hit | (paddr[7] & pwrite);
                    end else begin
                        acc_err = 1'b1;
                    end
                end
            endcase
        end
    end

    // Bus response and write-strobe registers.
    always_ff @(posedge pclk) begin
        if (prst) begin
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= '0;
            wr_ctrl    <= 1'b0;
            wr_int_en  <= 1'b0;
            wr_int_clr <= 1'b0;
            wr_int_set <= 1'b0;
            wr_step    <= 1'b0;
            wr_tgt     <= '0;
            wr_data    <= '0;
        end else begin
            pready     <= access;
            pslverr    <= access & acc_err;
            if (access) begin
                prdata  <= (acc_err | pwrite) ? 32'h0 : rd_data;
                wr_data <= pwdata;
            end
            wr_ctrl    <= access & pwrite & ~acc_err & hit_ctrl;
            wr_int_en  <= access & pwrite & ~acc_err & hit_int_en;
            wr_int_clr <= access & pwrite & ~acc_err & hit_int_stat;
            wr_int_set <= access & pwrite & ~acc_err & hit_int_set;
            wr_step    <= access & pwrite & ~acc_err & hit_step;
            wr_tgt     <= hit_tgt & {NUM_CH{access & pwrite & ~acc_err}};
        end
    end

    // Plain read/write configuration registers.
    always_ff @(posedge pclk) begin
        if (prst) begin
            ctrl_en_q   <= '0;
            bypass_q    <= 1'b0;
            int_en_q    <= '0;
            ramp_step_q <= STEP_RST;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q <= wr_data[7:0];
                bypass_q  <= wr_data[31];
            end
            if (wr_int_en) int_en_q    <= wr_data[IW-1:0];
            if (wr_step)   ramp_step_q <= wr_data[15:0];
        end
    end

    assign ctrl_enable = ctrl_en_q;

    logic [15:0]       vol_nxt [NUM_CH];
    logic [15:0]       tgt_nxt [NUM_CH];
    logic [NUM_CH-1:0] busy_nxt;
    logic [15:0]       diff;
    logic              busy_fall;

    // Next volume per channel: bypass copies the target, otherwise each tick
    // moves by the step clamped to the remaining distance (never overshoots).
    always_comb begin
        diff = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            tgt_nxt[n] = wr_tgt[n] ? wr_data[15:0] : vol_tgt[n];
            vol_nxt[n] = vol_cur[n];
            if (bypass_q) begin
                vol_nxt[n] = vol_tgt[n];
            end else if (ramp_tick) begin
                if (vol_cur[n] < vol_tgt[n]) begin
                    diff       = vol_tgt[n] - vol_cur[n];
                    vol_nxt[n] = vol_cur[n] + ((diff < ramp_step_q) ? diff : ramp_step_q);
                end else begin
                    diff       = vol_cur[n] - vol_tgt[n];
                    vol_nxt[n] = vol_cur[n] - ((diff < ramp_step_q) ? diff : ramp_step_q);
                end
            end
            busy_nxt[n] = (vol_nxt[n] != tgt_nxt[n]);
        end
        busy_fall = |(ramp_busy & ~busy_nxt);
    end

    // Volume target, current volume and busy flags.
    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                vol_tgt[n] <= '0;
                vol_cur[n] <= '0;
            end
            ramp_busy <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                vol_tgt[n] <= tgt_nxt[n];
                vol_cur[n] <= vol_nxt[n];
            end
            ramp_busy <= busy_nxt;
        end
    end

    // Pack per-channel volumes onto the flat output bus.
    always_comb begin
        vol_out = '0;
        for (int n = 0; n < NUM_CH; n++) vol_out[16*n +: 16] = vol_cur[n];
    end

    logic [IW-1:0] hw_set;
    assign hw_set = {busy_fall, irq_src & ~irq_hist_q & {NUM_IRQ{edge_en_q}}};

    // Interrupt status: hardware and software sets take priority over W1C.
    // Edge detection stays off for the first cycle after reset so a source
    // already high at release is absorbed into the history, not latched.
    always_ff @(posedge pclk) begin
        if (prst) begin
            int_stat_q <= '0;
            irq_hist_q <= '0;
            edge_en_q  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            int_stat_q <= (int_stat_q & ~(wr_int_clr ? wr_data[IW-1:0] : '0))
                        | (wr_int_set ? wr_data[IW-1:0] : '0)
                        | hw_set;
            irq_hist_q <= irq_src;
            edge_en_q  <= 1'b1;
            irq        <= |(int_stat_q & int_en_q);
        end
    end

endmodule

// File: doc/audio_csr_bank.md
AUDIO_CSR_BANK -- requirements
Module: audio_csr_bank

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of volume channels (range 1..32).
REQ-002 Parameter NUM_IRQ, default 8, SHALL set the number of external interrupt sources (range 1..31).
REQ-003 Parameter STEP_RST, default 16'h0010, SHALL set the reset value of RAMP_STEP.
REQ-004 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-005 The ports SHALL be as follows:
- pclk  in  1  clock
- prst  in  1  synchronous active-high reset
- paddr  in  12  APB byte address
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- pwdata  in  32  write data
- prdata  out  32  read data, valid while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error, valid while pready=1
- version  in  32  static IP version
- irq_src  in  NUM_IRQ  level interrupt sources
- ramp_tick  in  1  single-cycle volume-ramp strobe
- ctrl_enable  out  8  CTRL[7:0]
- vol_out  out  NUM_CH*16  current volume, channel n at [16n+15:16n]
- ramp_busy  out  NUM_CH  vol_out differs from target
- irq  out  1  interrupt request

Function
REQ-006 The address map SHALL be:
- 0x000 CTRL, RW: bits 7:0 are enables; bit 31 is RAMP_BYPASS.
- 0x004 VERSION, RO: reads the version input.
- 0x008 INT_EN, RW: bits NUM_IRQ:0.
- 0x00C INT_STAT, W1C: bits NUM_IRQ:0.
- 0x010 INT_SET, WO: write-1-to-set INT_STAT; reads 0.
- 0x014 RAMP_STEP, RW: bits 15:0.
- 0x100+4n VOL_TGT[n], RW: bits 15:0.
- 0x180+4n VOL_CUR[n], RO: bits 15:0.
REQ-007 Unimplemented register bits SHALL read 0 and SHALL ignore writes.
REQ-008 Each APB transfer SHALL take exactly one wait state.
- First access cycle (psel & penable & ~pready): pready=0.
- Next cycle: pready=1 for exactly one cycle.
- Cycle after that: pready=0.
REQ-009 The block SHALL sample paddr, pwrite and pwdata in the first access cycle.
REQ-010 The block SHALL commit a write on the clock edge ending the pready=1 cycle.
REQ-011 Read data SHALL be registered and SHALL reflect register state as of the first access cycle.
REQ-012 pslverr SHALL be 1 with pready for: an unmapped address, channel n≥NUM_CH, a write to VERSION or VOL_CUR, or paddr[1:0]≠0.
REQ-013 Errored writes SHALL have no effect, and errored reads SHALL return 0.
REQ-014 Outside the pready=1 cycle, pslverr=0 and prdata holds its last value.
REQ-015 INT_STAT[i] (i<NUM_IRQ) SHALL set on a rising edge of irq_src[i], detected against a registered copy of irq_src.
REQ-016 INT_STAT[NUM_IRQ] SHALL set on the cycle any ramp_busy bit falls 1→0.
REQ-017 When a hardware set and a W1C clear of the same bit occur in one cycle, set SHALL win.
REQ-018 An INT_SET write SHALL OR pwdata into INT_STAT.
REQ-019 irq SHALL be registered as |(INT_STAT & INT_EN), one cycle after INT_STAT/INT_EN change.
REQ-020 Per channel, while RAMP_BYPASS=0, on each ramp_tick: vol_out moves toward VOL_TGT by min(RAMP_STEP, |VOL_TGT−vol_out|), using unsigned 16-bit arithmetic with no overshoot or wrap.
REQ-021 With RAMP_STEP=0, vol_out SHALL hold its value.
REQ-022 With RAMP_BYPASS=1, vol_out SHALL equal VOL_TGT on the cycle after any change, ignoring ramp_tick.
REQ-023 A VOL_TGT write coincident with ramp_tick SHALL cause the step to use the old target; the new target applies from the next tick.
REQ-024 ramp_busy[n] SHALL be registered and equal (vol_out[n]≠VOL_TGT[n]).
REQ-025 VOL_CUR[n] SHALL read vol_out[n].
REQ-026 ctrl_enable SHALL be driven directly from the CTRL register flop.

Reset
REQ-027 While prst=1, the block SHALL reset:
- CTRL, INT_EN, INT_STAT, VOL_TGT and vol_out to 0;
- RAMP_STEP to STEP_RST;
- prdata, pready, pslverr, irq, ramp_busy and the irq_src history to 0.
REQ-028 Reset asserted mid-transfer SHALL abort it, and the bus SHALL restart from idle after reset with no write committed.
REQ-029 irq_src high at reset release SHALL NOT set INT_STAT, because the history register resets to 0 and is then loaded from irq_src before edge detection is enabled.

Verification
REQ-030 Write 0x1234 to 0x104, then read 0x104 → pready high on the second access cycle, prdata=0x00001234, pslverr=0.
REQ-031 Read 0x0F0 and write 0x004 → pslverr=1, read data 0, VERSION unchanged.
REQ-032 INT_EN=0x1, pulse irq_src[0] → INT_STAT=0x1, irq=1 one cycle later; write 0x1 to 0x00C → irq=0. Repeat with the W1C landing on the same cycle as a new irq_src[0] edge → bit stays 1.
REQ-033 RAMP_STEP=0x10, VOL_TGT[0]=0x25, 3 ramp_ticks → vol_out[0] = 0x10, 0x20, 0x25; ramp_busy[0] falls; INT_STAT[NUM_IRQ]=1.
REQ-034 RAMP_BYPASS=1, VOL_TGT[1]=0xFFFF → vol_out[1]=0xFFFF next cycle with no tick. Then target 0x0000 with bypass off, step 0xFFFF → one tick reaches 0 with no wrap.
REQ-035 Assert prst during the wait-state cycle of a write to 0x000 → CTRL=0 and pready=0 after reset; a subsequent transfer completes normally.
